// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline, with a memory-wait timeout and performance counters.
// Optional macro HAZARD_FORWARDING_EN: forwarding unit present, so only load-use in EXE stalls.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           id_src1,
  input  logic [3:0]           id_src2,
  input  logic                 id_uses_src1,
  input  logic                 id_two_src,
  input  logic [3:0]           exe_dest,
  input  logic [3:0]           mem_dest,
  input  logic                 exe_wb_en,
  input  logic                 mem_wb_en,
  input  logic                 exe_mem_read,
  input  logic                 exe_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_freeze,
  output logic                 if_id_freeze,
  output logic                 id_ex_freeze,
  output logic                 ex_mem_freeze,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
  output logic                 mem_stall,
  output logic                 data_hazard,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [15:0]          TIMEOUT_C  = 16'(MEM_TIMEOUT);
  localparam logic [15:0]          WAIT_MAX_C = 16'hFFFF;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX_C  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE_C  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic reg_match(input logic [3:0] src, input logic en, input logic [3:0] dest);
    return en && (dest == src);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    if (val == CNT_MAX_C) begin
      return val;
    end else begin
      return val + CNT_ONE_C;
    end
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [15:0]            mem_wait_cnt_r;
  logic                   mem_timeout_r;
  logic [CNT_WIDTH-1:0]   stall_cycles_r;
  logic [CNT_WIDTH-1:0]   flush_events_r;
  logic                   mem_stall_s;
  logic                   exe_hit_s;
  logic                   hazard_s;
  logic                   branch_flush_s;

  assign mem_stall_s = !rst && mem_req && !mem_ready;

  assign exe_hit_s = (id_uses_src1 && reg_match(id_src1, exe_wb_en, exe_dest)) ||
                     (id_two_src   && reg_match(id_src2, exe_wb_en, exe_dest));

`ifdef HAZARD_FORWARDING_EN
  // Forwarded results cover everything except a load still in EXE.
  logic unused_mem_s;
  assign unused_mem_s = ^{mem_wb_en, mem_dest};
  assign hazard_s     = exe_mem_read && exe_hit_s;
`else
  logic mem_hit_s;
  logic unused_load_s;
  assign mem_hit_s     = (id_uses_src1 && reg_match(id_src1, mem_wb_en, mem_dest)) ||
                         (id_two_src   && reg_match(id_src2, mem_wb_en, mem_dest));
  assign unused_load_s = exe_mem_read;
  assign hazard_s      = exe_hit_s || mem_hit_s;
`endif

  // Memory-handshake FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_nxt_s = ST_MEM_WAIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_MEM_WAIT;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Prioritised freeze/flush decode: memory stall, then taken branch, then data hazard.
  always_comb begin
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    id_ex_freeze   = 1'b0;
    ex_mem_freeze  = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_wb_flush   = 1'b0;
    data_hazard    = 1'b0;
    branch_flush_s = 1'b0;
    if (rst) begin
      branch_flush_s = 1'b0;
    end else if (mem_stall_s) begin
      pc_freeze     = 1'b1;
      if_id_freeze  = 1'b1;
      id_ex_freeze  = 1'b1;
      ex_mem_freeze = 1'b1;
      mem_wb_flush  = 1'b1;
    end else if (exe_branch_taken) begin
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      branch_flush_s = 1'b1;
    end else if (hazard_s) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_ex_flush  = 1'b1;
      data_hazard  = 1'b1;
    end else begin
      branch_flush_s = 1'b0;
    end
  end

  // State register, wait counter, sticky timeout and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_RUN;
      mem_wait_cnt_r <= 16'd0;
      mem_timeout_r  <= 1'b0;
      stall_cycles_r <= {CNT_WIDTH{1'b0}};
      flush_events_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (mem_stall_s) begin
        if (mem_wait_cnt_r != WAIT_MAX_C) begin
          mem_wait_cnt_r <= mem_wait_cnt_r + 16'd1;
        end
        if (mem_wait_cnt_r == TIMEOUT_C) begin
          mem_timeout_r <= 1'b1;
        end
      end else begin
        mem_wait_cnt_r <= 16'd0;
      end
      if (data_hazard || mem_stall_s) begin
        stall_cycles_r <= sat_inc(stall_cycles_r);
      end
      if (branch_flush_s) begin
        flush_events_r <= sat_inc(flush_events_r);
      end
    end
  end

  assign mem_stall    = mem_stall_s;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_events = flush_events_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan sequences, counter saturation, then random traffic.
module tb_pipeline_hazard_ctrl;
  localparam int TMO     = 3;
  localparam int CW      = 8;
  localparam int CNT_SAT = 255;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_uses_src1, id_two_src, exe_wb_en, mem_wb_en, exe_mem_read;
  logic exe_branch_taken, mem_req, mem_ready;
  logic pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_stall, data_hazard, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src1(id_uses_src1), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
    .exe_mem_read(exe_mem_read), .exe_branch_taken(exe_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .id_ex_freeze(id_ex_freeze), .ex_mem_freeze(ex_mem_freeze),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .mem_stall(mem_stall),
    .data_hazard(data_hazard), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct {
    logic [8:0] ctl;
    int         stall;
    int         flush;
    bit         tmo;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference-model state: counters as plain integers, stall run length unbounded.
  int m_stall = 0;
  int m_flush = 0;
  int m_run   = 0;
  bit m_tmo   = 1'b0;

  function automatic bit model_hazard();
    bit hz = 1'b0;
    logic [3:0] s;
    bit used;
    for (int i = 0; i < 2; i++) begin
      s    = (i == 0) ? id_src1 : id_src2;
      used = (i == 0) ? id_uses_src1 : id_two_src;
      if (used) begin
`ifdef HAZARD_FORWARDING_EN
        if (exe_mem_read && exe_wb_en && exe_dest == s) hz = 1'b1;
`else
        if (exe_wb_en && exe_dest == s) hz = 1'b1;
        if (mem_wb_en && mem_dest == s) hz = 1'b1;
`endif
      end
    end
    return hz;
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1;
  endfunction

  // Predict this cycle's response, queue it, then advance the model across the clock edge.
  task automatic step();
    exp_t e;
    bit st, brf, dh;
    st  = !rst && mem_req && !mem_ready;
    brf = !rst && !st && exe_branch_taken;
    dh  = !rst && !st && !exe_branch_taken && model_hazard();
    if (rst)      e.ctl = 9'b000000000;
    else if (st)  e.ctl = 9'b111100110;
    else if (brf) e.ctl = 9'b000011000;
    else if (dh)  e.ctl = 9'b110001001;
    else          e.ctl = 9'b000000000;
    e.stall = m_stall;
    e.flush = m_flush;
    e.tmo   = m_tmo;
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_tmo = 1'b0;
    end else begin
      if (st) begin
        m_run++;
        if (m_run > TMO) m_tmo = 1'b1;
      end else begin
        m_run = 0;
      end
      if (st || dh) m_stall = sat(m_stall);
      if (brf) m_flush = sat(m_flush);
    end
    #1;
  endtask

  task automatic clr();
    id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
    id_uses_src1 = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
    exe_mem_read = 1'b0; exe_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use(input bit is_load);
    exe_mem_read = is_load; exe_wb_en = 1'b1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_uses_src1 = 1'b1;
  endtask

  // Monitor: compare every presented response against the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      act = {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_stall, data_hazard};
      checks += 4;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl @%0t: got %b expected %b", $time, act, e.ctl);
      end
      if (int'(stall_cycles) != e.stall || $isunknown(stall_cycles)) begin
        errors++;
        $display("FAIL stall_cycles @%0t: got %0d expected %0d", $time, stall_cycles, e.stall);
      end
      if (int'(flush_events) != e.flush || $isunknown(flush_events)) begin
        errors++;
        $display("FAIL flush_events @%0t: got %0d expected %0d", $time, flush_events, e.flush);
      end
      if (mem_timeout !== e.tmo) begin
        errors++;
        $display("FAIL mem_timeout @%0t: got %b expected %b", $time, mem_timeout, e.tmo);
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a pending memory wait, then release.
    mem_req = 1'b1; mem_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    mem_ready = 1'b1; step();
    clr(); step();

    // Load-use, then the same dependency without a load.
    load_use(1'b1); step();
    clr(); step();
    load_use(1'b0); step();
    clr(); step();

    // MEM-stage RAW on src2.
    mem_wb_en = 1'b1; mem_dest = 4'd5; id_two_src = 1'b1; id_src2 = 4'd5; step();
    clr(); step();

    // Taken branch overrides a load-use match.
    load_use(1'b1); exe_branch_taken = 1'b1; step();
    clr(); step();

    // Memory wait of 4 cycles with a held taken branch, flushed on release.
    mem_req = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) step();
    mem_ready = 1'b1; step();
    clr(); step();

    // Timeout: stall beyond MEM_TIMEOUT, sticky through release, cleared by reset.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) step();
    mem_ready = 1'b1; step();
    clr(); step(); step();
    rst = 1'b1; mem_req = 1'b1; step();
    rst = 1'b0; clr(); step();

    // Counter saturation: alternate branch flush and hazard stall.
    load_use(1'b1);
    for (int i = 0; i < 540; i++) begin
      exe_branch_taken = i[0];
      step();
    end
    clr(); step();

    // Randomised traffic with small register ranges to provoke matches.
    for (int i = 0; i < 800; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      id_src1          = 4'($urandom_range(0, 3));
      id_src2          = 4'($urandom_range(0, 3));
      exe_dest         = 4'($urandom_range(0, 3));
      mem_dest         = 4'($urandom_range(0, 3));
      id_uses_src1     = 1'($urandom_range(0, 1));
      id_two_src       = 1'($urandom_range(0, 1));
      exe_wb_en        = 1'($urandom_range(0, 1));
      mem_wb_en        = 1'($urandom_range(0, 1));
      exe_mem_read     = 1'($urandom_range(0, 1));
      exe_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req          = 1'($urandom_range(0, 1));
      mem_ready        = ($urandom_range(0, 2) != 0);
      step();
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It watches ID-stage source registers against EXE- and MEM-stage destinations, EXE-stage branch resolution, and the MEM-stage memory handshake. It drives the freeze and flush controls that the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers consume. It also counts stall and flush events for performance debug, and detects memory-handshake timeouts.

## Interface
- MEM_TIMEOUT, 255: number of consecutive memory-wait cycles after which `mem_timeout` is set (1..65535).
- CNT_WIDTH, 32: width of the performance counters.

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1, id_src2  in  4  ID-stage Rn / Rm register indices.
- id_uses_src1  in  1  ID instruction reads Rn.
- id_two_src  in  1  ID instruction reads Rm (register operand or store data).
- exe_dest, mem_dest  in  4  destination register index in EXE / MEM stage.
- exe_wb_en, mem_wb_en  in  1  EXE / MEM instruction writes back.
- exe_mem_read  in  1  EXE instruction is a load.
- exe_branch_taken  in  1  branch resolved taken in EXE.
- mem_req  in  1  MEM instruction is a load or store.
- mem_ready  in  1  memory has completed the current MEM-stage access.
- pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze  out  1  hold the corresponding register.
- if_id_flush, id_ex_flush  out  1  load a bubble (all zeros) into the corresponding register.
- mem_wb_flush  out  1  insert a bubble into MEM/WB while memory is stalled.
- mem_stall  out  1  memory wait in progress.
- data_hazard  out  1  load-use or RAW stall in effect this cycle.
- mem_timeout  out  1  sticky error flag.
- stall_cycles, flush_events  out  CNT_WIDTH  saturating performance counters.

## Operation
- All freeze and flush outputs are combinational from the inputs and the FSM state. Stage registers act on them at the next rising edge.
- FSM states are RUN and MEM_WAIT. Reset state is RUN.
  - RUN → MEM_WAIT when `mem_req && !mem_ready`.
  - MEM_WAIT → RUN when `mem_ready`.
- `mem_stall = mem_req && !mem_ready`, in either state.
- Priority 1, memory stall:
  - pc, IF/ID, ID/EX and EX/MEM freezes are all 1.
  - `mem_wb_flush` is 1.
  - Branch and hazard outputs are 0; `data_hazard` is 0.
- Priority 2, branch taken:
  - `if_id_flush` and `id_ex_flush` are 1; all freezes are 0.
  - The hazard check is suppressed because the ID instruction is discarded.
- Priority 3, data hazard:
  - `pc_freeze`, `if_id_freeze` and `id_ex_flush` are 1, inserting one bubble.
  - `data_hazard` is 1.
- Source match rule: `match(s, en, d) = en && d == s`. It is checked for src1 only when `id_uses_src1`, and for src2 only when `id_two_src`.
- `mem_wait_cnt` (16 bit):
  - Increments each cycle `mem_stall` is 1, saturating at 65535.
  - Cleared to 0 in any cycle `mem_stall` is 0.
  - When the counter equals MEM_TIMEOUT while `mem_stall` is 1, `mem_timeout` is set and stays 1 until `rst`.
  - Stalling continues after the timeout.
- `stall_cycles`: +1 each cycle `data_hazard || mem_stall`.
- `flush_events`: +1 each cycle the branch flush is applied.
- Both counters saturate at all-ones.

## Timing
- Reset values: state RUN, `mem_wait_cnt` 0, `mem_timeout` 0, `stall_cycles` 0, `flush_events` 0.
- With `rst` high, every freeze/flush output, `data_hazard` and `mem_stall` is 0.
- `rst` takes precedence over all inputs, including mid-MEM_WAIT: state returns to RUN the next edge.
- Latency:
  - Control outputs follow inputs in the same cycle, with zero registered latency.
  - Counters and `mem_timeout` update at the edge after the qualifying cycle.
- A load-use case costs exactly 1 stall cycle. A branch costs 2 flushed slots, both flushed in one cycle.
- Branch taken during a memory stall: the branch is held in frozen ID/EX. The flush is applied in the first cycle after `mem_ready`.
- `mem_ready` high in the same cycle `mem_req` rises: no stall and no state change.

## Configuration
- `HAZARD_FORWARDING_EN` defined, forwarding unit present:
  - A data hazard occurs only on load-use, i.e. `exe_mem_read` AND match(src, `exe_wb_en`, `exe_dest`).
  - MEM-stage matches are ignored.
- `HAZARD_FORWARDING_EN` undefined: a data hazard occurs on any match against EXE (`exe_wb_en`/`exe_dest`) or MEM (`mem_wb_en`/`mem_dest`), independent of `exe_mem_read`.

## Test plan
- Reset: hold `rst` 2 cycles with `mem_req=1`, `mem_ready=0` → all outputs 0. Release → `mem_stall=1` in the same cycle.
- Load-use: `exe_mem_read=1`, `exe_wb_en=1`, `exe_dest=3`, `id_src1=3`, `id_uses_src1=1` → `pc_freeze`, `if_id_freeze`, `id_ex_flush` and `data_hazard` all 1; `stall_cycles` goes 0→1. Same stimulus with `exe_mem_read=0` → hazard only when `HAZARD_FORWARDING_EN` is undefined.
- MEM RAW without forwarding: `mem_wb_en=1`, `mem_dest=5`, `id_two_src=1`, `id_src2=5` → `data_hazard=1`. With `HAZARD_FORWARDING_EN` → `data_hazard=0`.
- Branch over hazard: `exe_branch_taken=1` plus load-use match → `if_id_flush=1`, `id_ex_flush=1`, `pc_freeze=0`, `data_hazard=0`; `flush_events=1`.
- Memory wait: `mem_req=1`, `mem_ready=0` for 4 cycles then 1 → all freezes 1 and `mem_wb_flush=1` for 4 cycles; state RUN→MEM_WAIT→RUN; `stall_cycles=4`. A taken branch held during the wait flushes in cycle 5.
- Timeout: MEM_TIMEOUT=3 with `mem_ready` held 0 → `mem_timeout` rises after the 4th stalled cycle's edge. It stays 1 after `mem_ready`, and clears only on `rst`.
